// File: rtl/hc_sync_down_counter.sv
// Presettable synchronous binary down-counter with CEP/CET enables and cascadable TC.
// Optional auto-reload on underflow when HC_DOWN_AUTO_RELOAD_EN is defined.
module hc_sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             CEP,
    input  logic             CET,
    input  logic             PE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             UF
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] wrap;
    logic             uf_nxt;
    logic             cnt;
    logic             q_zero;

    assign cnt    = CEP & CET;
    assign q_zero = (Q == '0);

`ifdef HC_DOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r;

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            r <= '0;
        end else if (!PE) begin
            r <= D;
        end
    end

    assign wrap = r;
`else
    assign wrap = '1;
`endif

    // Load has priority over counting; UF only marks a counted wrap.
    always_comb begin
        q_nxt  = Q;
        uf_nxt = 1'b0;
        unique case (1'b1)
            !PE: begin
                q_nxt = D;
            end
            PE && cnt: begin
                if (q_zero) begin
                    q_nxt  = wrap;
                    uf_nxt = 1'b1;
                end else begin
                    q_nxt = Q - ONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            Q  <= '0;
            UF <= 1'b0;
        end else begin
            Q  <= q_nxt;
            UF <= uf_nxt;
        end
    end

    assign TC = CET & q_zero;

endmodule

// File: tb/tb_hc_sync_down_counter.sv
// Scoreboard bench for hc_sync_down_counter: single stage plus a 2x4-bit cascade.
// Expected responses are queued by stimulus and checked by a separate monitor.
module tb_hc_sync_down_counter;

    logic       CP;
    logic       MR;
    logic       CEP;
    logic       CET;
    logic       PE;
    logic [3:0] D;
    logic [3:0] Q;
    logic       TC;
    logic       UF;

    logic       c_pe;
    logic       c_cep;
    logic       c_cet;
    logic [7:0] c_d;
    logic [3:0] lq;
    logic [3:0] hq;
    logic       ltc;
    logic       htc;
    logic       luf;
    logic       huf;

    hc_sync_down_counter #(.WIDTH(4)) dut (
        .CP(CP), .MR(MR), .CEP(CEP), .CET(CET), .PE(PE),
        .D(D), .Q(Q), .TC(TC), .UF(UF)
    );

    hc_sync_down_counter #(.WIDTH(4)) c_lo (
        .CP(CP), .MR(MR), .CEP(c_cep), .CET(c_cet), .PE(c_pe),
        .D(c_d[3:0]), .Q(lq), .TC(ltc), .UF(luf)
    );

    hc_sync_down_counter #(.WIDTH(4)) c_hi (
        .CP(CP), .MR(MR), .CEP(c_cep), .CET(ltc), .PE(c_pe),
        .D(c_d[7:4]), .Q(hq), .TC(htc), .UF(huf)
    );

    typedef struct {
        string      nm;
        bit         kind;
        logic [3:0] q;
        logic       tc;
        logic       uf;
        logic [7:0] cv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // Monitor: each sample request pops one expectation and compares.
    initial begin
        forever begin
            @(sample_ev);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underrun: sample with empty queue");
            end else begin
                mon_e = sb.pop_front();
                if (!mon_e.kind) begin
                    if (Q !== mon_e.q || TC !== mon_e.tc || UF !== mon_e.uf) begin
                        errors++;
                        $display("FAIL %s: got Q=%0d TC=%b UF=%b want Q=%0d TC=%b UF=%b",
                                 mon_e.nm, Q, TC, UF, mon_e.q, mon_e.tc, mon_e.uf);
                    end
                end else begin
                    if ({hq, lq} !== mon_e.cv) begin
                        errors++;
                        $display("FAIL %s: got 0x%02h want 0x%02h",
                                 mon_e.nm, {hq, lq}, mon_e.cv);
                    end
                end
            end
        end
    end

    task automatic step(input string nm, input logic pe_i, input logic cep_i,
                        input logic cet_i, input logic [3:0] d_i,
                        input logic [3:0] eq, input logic etc, input logic euf);
        PE  = pe_i;
        CEP = cep_i;
        CET = cet_i;
        D   = d_i;
        @(posedge CP);
        sb.push_back('{nm: nm, kind: 1'b0, q: eq, tc: etc, uf: euf, cv: 8'h00});
        -> sample_ev;
        @(negedge CP);
    endtask

    task automatic acheck(input string nm, input logic [3:0] eq,
                          input logic etc, input logic euf);
        sb.push_back('{nm: nm, kind: 1'b0, q: eq, tc: etc, uf: euf, cv: 8'h00});
        -> sample_ev;
        #2;
    endtask

    task automatic cstep(input string nm, input logic pe_i,
                         input logic [7:0] d_i, input logic [7:0] ecv);
        c_pe  = pe_i;
        c_cep = 1'b1;
        c_d   = d_i;
        @(posedge CP);
        sb.push_back('{nm: nm, kind: 1'b1, q: 4'h0, tc: 1'b0, uf: 1'b0, cv: ecv});
        -> sample_ev;
        @(negedge CP);
    endtask

    initial begin
        MR    = 1'b0;
        PE    = 1'b1;
        CEP   = 1'b0;
        CET   = 1'b1;
        D     = 4'h0;
        c_pe  = 1'b1;
        c_cep = 1'b0;
        c_cet = 1'b1;
        c_d   = 8'h00;

        #3;
        acheck("reset_tc_cet1", 4'd0, 1'b1, 1'b0);
        CET = 1'b0;
        acheck("reset_tc_cet0", 4'd0, 1'b0, 1'b0);
        @(negedge CP);
        MR  = 1'b1;
        CET = 1'b1;

        step("load9", 1'b0, 1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0);
        MR = 1'b0;
        acheck("mr_mid_cycle", 4'd0, 1'b1, 1'b0);
        CET = 1'b0;
        acheck("mr_mid_cet0", 4'd0, 1'b0, 1'b0);
        @(negedge CP);
        MR = 1'b1;

        step("load3", 1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
        step("cnt_2", 1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0);
        step("cnt_1", 1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
        step("cnt_0", 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
`ifdef HC_DOWN_AUTO_RELOAD_EN
        step("cnt_wrap", 1'b1, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b1);
        step("cnt_after", 1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0);
`else
        step("cnt_wrap", 1'b1, 1'b1, 1'b1, 4'd0, 4'd15, 1'b0, 1'b1);
        step("cnt_after", 1'b1, 1'b1, 1'b1, 4'd0, 4'd14, 1'b0, 1'b0);
`endif

        step("load0", 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("hold_cep0", 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
        end
        step("hold_cet0", 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        CET = 1'b1;
        acheck("tc_follows_cet", 4'd0, 1'b1, 1'b0);
        step("load_prio", 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);

        step("load2", 1'b0, 1'b1, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0);
        step("r_1a", 1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
        step("r_0a", 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
`ifdef HC_DOWN_AUTO_RELOAD_EN
        step("r_2a", 1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b1);
        step("r_1b", 1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
        step("r_0b", 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
        step("r_2b", 1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b1);
`else
        step("r_15", 1'b1, 1'b1, 1'b1, 4'd0, 4'd15, 1'b0, 1'b1);
        step("r_14", 1'b1, 1'b1, 1'b1, 4'd0, 4'd14, 1'b0, 1'b0);
        step("r_13", 1'b1, 1'b1, 1'b1, 4'd0, 4'd13, 1'b0, 1'b0);
        step("r_12", 1'b1, 1'b1, 1'b1, 4'd0, 4'd12, 1'b0, 1'b0);
`endif

        cstep("casc_load", 1'b0, 8'h10, 8'h10);
`ifdef HC_DOWN_AUTO_RELOAD_EN
        cstep("casc_dec1", 1'b1, 8'h00, 8'h00);
        cstep("casc_dec2", 1'b1, 8'h00, 8'h10);
`else
        cstep("casc_dec1", 1'b1, 8'h00, 8'h0F);
        cstep("casc_dec2", 1'b1, 8'h00, 8'h0E);
`endif

        repeat (3) @(negedge CP);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: %0d left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: timeout reached want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hc_sync_down_counter.md
Name: hc_sync_down_counter

Overview:
Synchronous presettable binary down-counter. It is the count-down counterpart of the team's 74HC161-style up-counter, with the same control pin set and semantics: parallel load, count enables CEP and CET, and a cascadable terminal-count output. It is used for programmable dividers and for timeouts that count down to zero. Stages cascade by tying TC of stage n to CET of stage n+1.

Parameters:
WIDTH, 4, counter width in bits (legal range 2..16)

Ports:
CP   input   1      clock; all state changes on the rising edge
MR   input   1      master reset; asynchronous, active-low
CEP  input   1      count enable, parallel (not propagated to TC)
CET  input   1      count enable, trickle (gates TC)
PE   input   1      parallel enable, active-low synchronous load
D    input   WIDTH  parallel load data
Q    output  WIDTH  counter value
TC   output  1      terminal count: combinational, CET & (Q == 0)
UF   output  1      underflow pulse, registered, one cycle wide

Behaviour:
- Reset (MR low, asynchronous, independent of CP):
  - Q = 0, UF = 0, reload register (if present) = 0.
  - TC = CET during reset, because Q == 0.
  - Deassertion takes effect at the next rising CP edge. No count occurs while MR is low.
- Priority at a rising CP edge with MR high, highest first:
  1. PE low: Q <= D. CEP and CET are ignored. UF <= 0.
  2. CEP & CET high: Q <= Q - 1, modulo 2^WIDTH (0 wraps to all ones). UF <= 1 if and only if Q was 0 before the edge; otherwise UF <= 0.
  3. Otherwise: Q holds, UF <= 0.
- TC:
  - Purely combinational from CET and Q, with no register and zero latency.
  - Changes immediately when CET changes.
  - CEP has no effect on TC.
- UF:
  - Asserts for exactly one cycle, in the cycle after the 0 -> wrap edge.
  - Never asserts on a load, even when D == 0.
- Latency: Q updates one edge after the controlling inputs; TC follows Q combinationally.
- Simultaneous events:
  - PE low with CEP = CET = 1 and Q = 0: the load wins and UF stays 0.
  - MR falling mid-cycle clears everything at once, overriding any pending edge.
- Cascade rule: the upper stage decrements only in the cycle where the lower stage reads 0 with CET high. A 2 x 4-bit chain therefore behaves as an 8-bit down-counter.
- Width arithmetic: decrement is WIDTH-bit unsigned. No saturation.

Optional Feature:
Macro: HC_DOWN_AUTO_RELOAD_EN
- Defined:
  - A WIDTH-bit reload register R captures D on every load (PE low edge).
  - When a decrement occurs with Q == 0, Q <= R instead of all ones. UF still pulses.
  - This gives a free-running divide-by-(R+1).
  - R resets to 0 on MR, so after reset with no load the counter stays at 0 and UF pulses every enabled cycle.
- Undefined:
  - No R register is built.
  - Wrap is always 0 -> 2^WIDTH-1, exactly as in rule 2.

Test Plan:
- Reset: MR = 0 asynchronously mid-cycle with Q = 9 -> Q = 0 and UF = 0 immediately. With CET = 1, TC = 1; with CET = 0, TC = 0.
- Load and countdown (WIDTH = 4):
  - PE = 0, D = 3 for one edge, then PE = 1, CEP = CET = 1 -> Q sequence 3, 2, 1, 0, 15, 14.
  - TC is high only while Q = 0.
  - UF is high only in the cycle where Q = 15.
- Enables:
  - CEP = 0, CET = 1, Q = 0 for 3 edges -> Q holds 0, TC = 1, UF = 0.
  - CET = 0 -> TC = 0 and Q holds.
- Load priority: Q = 0, PE = 0, D = 0, CEP = CET = 1 -> Q = 0 after the edge, UF = 0.
- Cascade: two WIDTH = 4 instances with TC_low -> CET_high, loaded with 0x10 -> the combined value goes 0x10, 0x0F, 0x0E. The upper stage steps only at the low-stage 0 -> 15 transition.
- With HC_DOWN_AUTO_RELOAD_EN: load D = 2, then count -> Q sequence 2, 1, 0, 2, 1, 0, 2. UF pulses in each cycle where Q = 2 after a reload; no UF after the initial load.
